// File: rtl/adder_bench_pkg.sv
// Shared width definitions for the registered adder benchmark and its sink stage.
// The adder top and the accumulator both derive their widths from this package.
package adder_bench_pkg;

  localparam int ADDER_WIDTH_DEF = 34;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Adding COUNT values of (adder_width+1) bits needs clog2(COUNT) extra bits.
  function automatic int acc_width(input int adder_width, input int count);
    return adder_width + 1 + clog2(count);
  endfunction

endpackage

// File: rtl/sum_block_accumulator_if.sv
// Sum input stream and block-total output slot of the sum block accumulator.
// The master side is the upstream adder plus the downstream consumer.
interface sum_block_accumulator_if
  import adder_bench_pkg::*;
#(
  parameter int ADDER_WIDTH = ADDER_WIDTH_DEF,
  parameter int ACC_WIDTH   = acc_width(ADDER_WIDTH_DEF, 16),
  parameter int SEQ_WIDTH   = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDER_WIDTH:0]   in_sum;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_acc;
  logic [SEQ_WIDTH-1:0]   out_seq;

  modport master (
    output in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_seq
  );

  modport slave (
    input  in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_seq
  );
endinterface

// File: rtl/sum_acc_out_slot.sv
// One-entry valid/ready holding register for completed block totals.
// A load always wins over a drain, so a same-cycle drain+load keeps valid high.
module sum_acc_out_slot #(
  parameter int ACC_WIDTH = 37,
  parameter int SEQ_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] load_acc,
  input  logic [SEQ_WIDTH-1:0] load_seq,
  input  logic                 drain_ok,
  output logic                 valid,
  output logic [ACC_WIDTH-1:0] acc,
  output logic [SEQ_WIDTH-1:0] seq
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      acc   <= '0;
      seq   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      acc   <= load_acc;
      seq   <= load_seq;
    end else if (drain_ok) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sum_block_accumulator.sv
// Accumulates blocks of COUNT consecutive sums and hands each total, tagged with
// a wrapping block number, to a one-entry output slot. Only a block's last sample stalls.
module sum_block_accumulator
  import adder_bench_pkg::*;
#(
  parameter int  ADDER_WIDTH = ADDER_WIDTH_DEF,
  parameter int  COUNT       = 16,
  parameter int  SEQ_WIDTH   = 8,
  localparam int ACC_WIDTH   = acc_width(ADDER_WIDTH, COUNT)
) (
  input logic                   clk,
  input logic                   rst_n,
  sum_block_accumulator_if.slave bus
);

  localparam int CNT_W = clog2(COUNT);

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic [SEQ_WIDTH-1:0] seq;
  logic                 last;
  logic                 slot_free;
  logic                 accept;
  logic                 complete;
  logic [ACC_WIDTH-1:0] acc_sum;

  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ADDER_WIDTH:0] s);
    return a + ACC_WIDTH'(s);
  endfunction

  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign last         = (cnt == CNT_W'(COUNT - 1));
  assign slot_free    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = slot_free || !last;
  assign accept       = bus.in_valid && bus.in_ready;
  assign complete     = accept && last;
  assign acc_sum      = acc_add(acc, bus.in_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      seq <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
        seq <= seq + SEQ_WIDTH'(1);
      end else begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  sum_acc_out_slot #(
    .ACC_WIDTH (ACC_WIDTH),
    .SEQ_WIDTH (SEQ_WIDTH)
  ) u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (complete),
    .load_acc (acc_sum),
    .load_seq (seq),
    .drain_ok (bus.out_ready),
    .valid    (bus.out_valid),
    .acc      (bus.out_acc),
    .seq      (bus.out_seq)
  );

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Directed bench for sum_block_accumulator with COUNT=4, ADDER_WIDTH=34.
module tb_sum_block_accumulator;

  localparam int AW  = 34;
  localparam int CNT = 4;
  localparam int SW  = 8;
  localparam int ACW = 37;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  sum_block_accumulator_if #(.ADDER_WIDTH(AW), .ACC_WIDTH(ACW), .SEQ_WIDTH(SW)) bus ();

  sum_block_accumulator #(.ADDER_WIDTH(AW), .COUNT(CNT), .SEQ_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Upstream must hold in_sum steady while it waits for in_ready.
  logic        pend = 1'b0;
  logic [AW:0] pend_sum = '0;
  always @(posedge clk) begin
    if (rst_n && pend) chk("sum_stable", 64'(bus.in_sum), 64'(pend_sum));
    pend     <= rst_n && bus.in_valid && !bus.in_ready;
    pend_sum <= bus.in_sum;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic v, input logic [ACW-1:0] a,
                      input logic [SW-1:0] s);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
    chk({tag, "_acc"},   64'(bus.out_acc),   64'(a));
    chk({tag, "_seq"},   64'(bus.out_seq),   64'(s));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    // Asynchronous reset asserted mid-cycle
    #3 rst_n = 1'b0;
    #1;
    slot("reset", 1'b0, '0, '0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Two back-to-back blocks with the consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = AW'(i);
      chk("stream_ready", 64'(bus.in_ready), 64'd1);
      tick();
      if (i == 4) slot("blk0", 1'b1, 37'd10, 8'd0);
      if (i == 8) slot("blk1", 1'b1, 37'd26, 8'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    // Full-scale sums must not wrap the accumulator
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = {(AW+1){1'b1}};
      tick();
    end
    bus.in_valid = 1'b0;
    slot("width", 1'b1, 37'h1F_FFFF_FFFC, 8'd2);
    tick();

    // Backpressure: slot held, next block stalls only on its last sample
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = AW'(i);
      if (i >= 5) chk("bp_accept", 64'(bus.in_ready), 64'd1);
      tick();
    end
    bus.in_sum = AW'(8);
    chk("bp_stall", 64'(bus.in_ready), 64'd0);
    tick();
    tick();
    slot("bp_held", 1'b1, 37'd10, 8'd3);
    chk("bp_still_stall", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    slot("bp_next", 1'b1, 37'd26, 8'd4);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    // Same-cycle drain and complete keeps out_valid high
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = AW'(i);
      if (i == 8) bus.out_ready = 1'b1;
      tick();
      if (i >= 4 && i < 8) slot("sim_hold", 1'b1, 37'd10, 8'd5);
      if (i == 8) slot("sim_swap", 1'b1, 37'd26, 8'd6);
    end
    bus.in_valid = 1'b0;
    tick();

    // Reset mid-block drops the partial block and restarts numbering
    bus.in_valid = 1'b1;
    bus.in_sum   = AW'(100);
    tick();
    tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    slot("midrst", 1'b0, '0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_sum = AW'(1);
    for (int b = 0; b < 257; b++) begin
      for (int k = 0; k < 4; k++) begin
        bus.in_valid = 1'b1;
        tick();
      end
      if (b == 0)   slot("after_rst", 1'b1, 37'd4, 8'd0);
      if (b == 255) slot("seq_255", 1'b1, 37'd4, 8'd255);
      if (b == 256) slot("seq_wrap", 1'b1, 37'd4, 8'd0);
    end
    bus.in_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
